// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and width definitions for the arbitrated ALU.
package alu_pkg;

    localparam int unsigned DataW = 8;
    localparam int unsigned ResW  = 16;

    typedef enum logic [2:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpMul = 3'd2,
        OpDiv = 3'd3,
        OpAnd = 3'd4,
        OpOr  = 3'd5,
        OpXor = 3'd6,
        OpIll = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_div8.sv
// 8-cycle restoring divider with a one-cycle bypass for a zero divisor.
module alu_div8
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DataW-1:0] dividend,
    input  logic [DataW-1:0] divisor,
    output logic             done,
    output logic [DataW-1:0] quotient,
    output logic [DataW-1:0] remainder,
    output logic             div_zero
);

    logic             active_q;
    logic             zero_q;
    logic [2:0]       cnt_q;
    logic [DataW-1:0] quo_q;
    logic [DataW-1:0] rem_q;
    logic [DataW-1:0] dvs_q;

    logic [DataW:0]   shifted;
    logic [DataW:0]   diff;
    logic             fits;
    logic [DataW-1:0] quo_nxt;
    logic [DataW-1:0] rem_nxt;

    // The final step's outcome is presented combinationally so the owner can
    // capture it on the same edge that retires the eighth iteration.
    always_comb begin
        shifted = {rem_q, quo_q[DataW-1]};
        diff    = shifted - {1'b0, dvs_q};
        fits    = shifted >= {1'b0, dvs_q};
        rem_nxt = fits ? diff[DataW-1:0] : shifted[DataW-1:0];
        quo_nxt = {quo_q[DataW-2:0], fits};
    end

    always_comb begin
        done      = active_q && (zero_q || cnt_q == 3'd7);
        quotient  = zero_q ? 8'hFF : quo_nxt;
        remainder = zero_q ? quo_q : rem_nxt;
        div_zero  = zero_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            zero_q   <= 1'b0;
            cnt_q    <= 3'd0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            zero_q   <= (divisor == '0);
            cnt_q    <= 3'd0;
            quo_q    <= dividend;
            rem_q    <= '0;
            dvs_q    <= divisor;
        end else if (active_q) begin
            if (done) begin
                active_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 3'd1;
                quo_q <= quo_nxt;
                rem_q <= rem_nxt;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a small ALU with one result slot.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [7:0]      req0_a,
    input  logic [7:0]      req0_b,
    input  logic [2:0]      req0_op,
    input  logic [7:0]      req1_a,
    input  logic [7:0]      req1_b,
    input  logic [2:0]      req1_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [15:0]     rsp_result,
    output logic            rsp_err,
    output logic            busy
);

    alu_state_e state_q, state_d;

    logic            last_grant_q;
    logic [NREQ-1:0] grant;
    logic            accept;
    logic            sel;
    logic [7:0]      sel_a, sel_b;
    logic [2:0]      sel_op;

    logic [7:0]      a_q, b_q;
    alu_op_e         op_q;
    logic            id_q;
    logic            rsp_valid_q, rsp_id_q, rsp_err_q;
    logic [ResW-1:0] rsp_result_q;

    logic [ResW-1:0] alu_res;
    logic            alu_err;
    logic            exec_done;
    logic            div_start, div_done, div_zero;
    logic [7:0]      div_quo, div_rem;

    always_comb begin
        grant = '0;
        if (rst_n && state_q == StIdle) begin
            if (&req_valid) begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
        accept = |(req_valid & grant);
        sel    = grant[1];
        sel_a  = sel ? req1_a : req0_a;
        sel_b  = sel ? req1_b : req0_b;
        sel_op = sel ? req1_op : req0_op;
    end

    assign div_start = accept && (sel_op == OpDiv);

    alu_div8 u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (sel_a),
        .divisor   (sel_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem),
        .div_zero  (div_zero)
    );

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        unique case (op_q)
            OpAdd: alu_res = {8'h00, a_q} + {8'h00, b_q};
            OpSub: alu_res = {8'h00, a_q} - {8'h00, b_q};
            OpMul: alu_res = {8'h00, a_q} * {8'h00, b_q};
            OpDiv: begin
                alu_res = {div_rem, div_quo};
                alu_err = div_zero;
            end
            OpAnd: alu_res = {8'h00, a_q & b_q};
            OpOr:  alu_res = {8'h00, a_q | b_q};
            OpXor: alu_res = {8'h00, a_q ^ b_q};
            OpIll: alu_err = 1'b1;
            default: alu_err = 1'b1;
        endcase
        exec_done = (op_q != OpDiv) || div_done;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StExec;
            StExec: if (exec_done) state_d = StDone;
            StDone: if (rsp_valid_q && rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = grant;
        busy       = (state_q != StIdle);
        rsp_valid  = rsp_valid_q;
        rsp_id     = rsp_id_q;
        rsp_result = rsp_result_q;
        rsp_err    = rsp_err_q;
    end

    // The response registers are loaded on leaving EXEC; rsp_valid follows one
    // edge later so the result is already settled when it is advertised.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OpAdd;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            if (accept) begin
                a_q          <= sel_a;
                b_q          <= sel_b;
                op_q         <= alu_op_e'(sel_op);
                id_q         <= sel;
                last_grant_q <= sel;
            end
            if (state_q == StExec && exec_done) begin
                rsp_result_q <= alu_res;
                rsp_err_q    <= alu_err;
                rsp_id_q     <= id_q;
            end
            if (state_q == StDone) begin
                if (!rsp_valid_q) begin
                    rsp_valid_q <= 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 The block SHALL have the parameter NREQ, default 2, fixed; it gives the number of requester ports, indices 0..1.
REQ-002 The block SHALL have the port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have the port req_valid, input, 2 bits: per-requester command valid.
REQ-005 The block SHALL have the port req_ready, output, 2 bits: per-requester command accept; one-hot or zero.
REQ-006 The block SHALL have the ports req0_a, req0_b, req1_a and req1_b, input, 8 bits each: operands.
REQ-007 The block SHALL have the ports req0_op and req1_op, input, 3 bits each: opcode.
REQ-008 The block SHALL have the port rsp_valid, output, 1 bit: result valid.
REQ-009 The block SHALL have the port rsp_ready, input, 1 bit: result consumed.
REQ-010 The block SHALL have the port rsp_id, output, 1 bit: index of the requester owning the result.
REQ-011 The block SHALL have the port rsp_result, output, 16 bits: the result.
REQ-012 The block SHALL have the port rsp_err, output, 1 bit: divide-by-zero or illegal opcode.
REQ-013 The block SHALL have the port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, EXEC and DONE.
REQ-015 In IDLE, req_ready SHALL be asserted to exactly one valid requester, chosen round-robin; all other req_ready bits SHALL be 0.
REQ-016 In EXEC and DONE, req_ready SHALL be 2'b00.
REQ-017 Round-robin: with both requesters valid, the grant SHALL go to the index not equal to last_grant; with one valid, the grant SHALL go to that one; last_grant SHALL update on every accept.
REQ-018 An accept occurs at the edge where req_valid[i] and req_ready[i] are both 1; at that edge the operands, opcode and index SHALL be latched and the FSM SHALL go IDLE->EXEC.
REQ-019 Opcodes SHALL be: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 illegal.
REQ-020 Width rules: operands SHALL be zero-extended to 16 bits.
REQ-021 ADD SHALL give a 9-bit sum.
REQ-022 SUB SHALL be computed modulo 2^16 (5-7 gives 16'hFFFE).
REQ-023 MUL SHALL give the full 16-bit product.
REQ-024 The logic ops AND, OR and XOR SHALL set bits 15:8 to 0.
REQ-025 DIV SHALL give rsp_result[7:0] = quotient and rsp_result[15:8] = remainder.
REQ-026 Non-DIV ops SHALL spend 1 cycle in EXEC; rsp_valid SHALL rise 2 cycles after the accept edge.
REQ-027 DIV with b != 0 SHALL run an iterative restoring divide of 8 EXEC cycles; rsp_valid SHALL rise 9 cycles after the accept edge.
REQ-028 DIV with b == 0 SHALL spend 1 EXEC cycle and SHALL give result {a, 8'hFF} with rsp_err = 1.
REQ-029 Opcode 7 SHALL give result 16'h0000 with rsp_err = 1 and a 1-cycle EXEC.
REQ-030 EXEC->DONE: rsp_valid, rsp_id, rsp_result and rsp_err SHALL be registered and held stable until rsp_ready.
REQ-031 DONE with rsp_ready = 1: at that edge rsp_valid SHALL drop and the FSM SHALL go to IDLE; the next accept is possible at the following edge.
REQ-032 There SHALL be no back-to-back overlap.
REQ-033 rsp_ready asserted while rsp_valid = 0 SHALL be ignored.
REQ-034 Changes to req_valid, operands or opcode after the accept SHALL not affect the in-flight operation.
REQ-035 A requester dropping req_valid before it is granted SHALL be legal; no accept shall occur for it.

Reset
REQ-036 While rst_n = 0 at a clock edge, the FSM SHALL go to IDLE and rsp_valid, rsp_err, rsp_id and busy SHALL be 0.
REQ-037 While rst_n = 0 at a clock edge, rsp_result SHALL be 16'h0000.
REQ-038 While rst_n = 0 at a clock edge, last_grant SHALL be 1, so requester 0 wins the first contention.
REQ-039 While rst_n = 0 at a clock edge, the divider state SHALL be cleared.
REQ-040 Reset during EXEC or DONE SHALL abandon the operation silently; no response shall be produced after reset release.
REQ-041 req_ready SHALL be 0 while rst_n = 0.

Structure
REQ-042 The shared package alu_pkg SHALL hold the opcode constants, the FSM state encoding and the widths 8 and 16.
REQ-043 The sub-module alu_div8 SHALL be the 8-cycle iterative divider, with start/done handshake and a zero-divisor bypass; all other ops SHALL be inline combinational logic sampled in EXEC.

Verification
REQ-044 Req0 alone requests ADD a=200, b=100 -> accept at T, rsp_valid at T+2, result 16'h012C, rsp_id 0, rsp_err 0.
REQ-045 Both requesters are valid continuously, both with MUL 255*255, and rsp_ready is held 1 -> grants alternate 0,1,0,1; each result is 16'hFE01.
REQ-046 DIV a=100, b=7 -> rsp_valid at T+9; result 16'h020E (remainder 2, quotient 14).
REQ-047 DIV a=9, b=0 -> rsp_valid at T+2; result 16'h09FF; rsp_err 1.
REQ-048 Opcode 7 -> result 16'h0000 and rsp_err 1; SUB 5-7 -> 16'hFFFE.
REQ-049 rsp_ready is held 0 for 10 cycles in DONE -> outputs stable and req_ready 0 throughout.
REQ-050 Reset asserted at the 4th EXEC cycle of a DIV -> all outputs at reset values; no rsp_valid after release; the next contention is won by requester 0.
